// File: rtl/sn74ls74_pkg.sv
// Shared constants for the dual D flip-flop block.
`timescale 1ns/1ps
package sn74ls74_pkg;
  localparam int   WIDTH_DEF  = 1;     // data bits per channel
  localparam int   SYNC_DEPTH = 2;     // input synchronizer stages
  localparam logic PREV_RST   = 1'b1;  // trigger history at reset: a high trigger must rise again
  localparam logic Q_RST      = 1'b0;  // state bit value at reset
endpackage

// File: rtl/sn74ls74_ff.sv
// One channel: optional input synchronizer, trigger rise detect, clear/preset forcing.
// Optional feature: SN74LS74_SYNC_EN adds a 2-stage synchronizer on trig and d.
`timescale 1ns/1ps
module sn74ls74_ff
  import sn74ls74_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_n,
  input  logic             pr_n,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);
  logic             trig_s;
  logic [WIDTH-1:0] d_s;
  logic             prev;
  logic             capture;
  logic             both_low;
  logic [WIDTH-1:0] q_reg;

`ifdef SN74LS74_SYNC_EN
  logic [SYNC_DEPTH-1:0]            trig_sync;
  logic [SYNC_DEPTH-1:0][WIDTH-1:0] d_sync;

  // Shift trigger and data through the synchronizer chain; trigger resets high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sync <= '1;
      d_sync    <= '0;
    end else begin
      trig_sync <= {trig_sync[SYNC_DEPTH-2:0], trig};
      d_sync    <= {d_sync[SYNC_DEPTH-2:0], d};
    end
  end

  assign trig_s = trig_sync[SYNC_DEPTH-1];
  assign d_s    = d_sync[SYNC_DEPTH-1];
`else
  assign trig_s = trig;
  assign d_s    = d;
`endif

  // Trigger history tracks every edge, so a rise under clear/preset is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= PREV_RST;
    else     prev <= trig_s;
  end

  assign capture  = trig_s & ~prev;
  assign both_low = ~clr_n & ~pr_n;

  // State: async reset, async clear/preset, otherwise capture on trigger rise.
  always_ff @(posedge clk or posedge rst or negedge clr_n or negedge pr_n) begin
    if (rst)           q_reg <= {WIDTH{Q_RST}};
    else if (both_low) q_reg <= '1;
    else if (!clr_n)   q_reg <= '0;
    else if (!pr_n)    q_reg <= '1;
    else if (capture)  q_reg <= d_s;
  end

  // Outputs follow clear/preset levels directly so a release is seen without waiting
  // for clk; in the both-low state both outputs read high like the original part.
  assign q   = rst ? {WIDTH{Q_RST}} : both_low ? '1 : !clr_n ? '0 : !pr_n ? '1 : q_reg;
  assign q_n = (!rst && both_low) ? '1 : ~q;
endmodule

// File: rtl/sn74ls74_dual.sv
// Dual D flip-flop with clk-sampled triggers and async clear/preset per channel.
// Optional feature: SN74LS74_SYNC_EN (input synchronizers, 3-clk capture latency).
`timescale 1ns/1ps
module sn74ls74_dual
  import sn74ls74_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk1,
  input  logic             clk2,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             clr1_n,
  input  logic             clr2_n,
  input  logic             pr1_n,
  input  logic             pr2_n,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q1_n,
  output logic [WIDTH-1:0] q2_n
);
  sn74ls74_ff #(.WIDTH(WIDTH)) u_ch1 (
    .clk(clk), .rst(rst), .trig(clk1), .d(d1), .clr_n(clr1_n), .pr_n(pr1_n),
    .q(q1), .q_n(q1_n)
  );

  sn74ls74_ff #(.WIDTH(WIDTH)) u_ch2 (
    .clk(clk), .rst(rst), .trig(clk2), .d(d2), .clr_n(clr2_n), .pr_n(pr2_n),
    .q(q2), .q_n(q2_n)
  );
endmodule

// File: tb/tb_sn74ls74_dual.sv
// Directed bench for sn74ls74_dual with a queue scoreboard of expected outputs.
`timescale 1ns/1ps
module tb_sn74ls74_dual;
  localparam int W = 4;
`ifdef SN74LS74_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    string        tag;
    logic [W-1:0] q1, q1n, q2, q2n;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic clk1 = 1'b1, clk2 = 1'b0;
  logic [W-1:0] d1 = 4'hF, d2 = 4'h0;
  logic clr1_n = 1'b1, clr2_n = 1'b1, pr1_n = 1'b1, pr2_n = 1'b1;
  logic [W-1:0] q1, q2, q1_n, q2_n;

  exp_t sb[$];
  int checks = 0;
  int errs   = 0;

  sn74ls74_dual #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clk1(clk1), .clk2(clk2), .d1(d1), .d2(d2),
    .clr1_n(clr1_n), .clr2_n(clr2_n), .pr1_n(pr1_n), .pr2_n(pr2_n),
    .q1(q1), .q2(q2), .q1_n(q1_n), .q2_n(q2_n)
  );

  always #1 clk = ~clk;

  // Land 0.2 ns after the n-th rising edge: inputs change and outputs are sampled here.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #0.2;
  endtask

  task automatic push(input string tag, input logic [W-1:0] e1, input logic [W-1:0] e1n,
                      input logic [W-1:0] e2, input logic [W-1:0] e2n);
    exp_t e;
    e.tag = tag; e.q1 = e1; e.q1n = e1n; e.q2 = e2; e.q2n = e2n;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (q1 === e.q1) else begin
      errs++; $error("FAIL %s q1 got %h exp %h", e.tag, q1, e.q1);
    end
    checks++;
    assert (q1_n === e.q1n) else begin
      errs++; $error("FAIL %s q1_n got %h exp %h", e.tag, q1_n, e.q1n);
    end
    checks++;
    assert (q2 === e.q2) else begin
      errs++; $error("FAIL %s q2 got %h exp %h", e.tag, q2, e.q2);
    end
    checks++;
    assert (q2_n === e.q2n) else begin
      errs++; $error("FAIL %s q2_n got %h exp %h", e.tag, q2_n, e.q2n);
    end
  endtask

  initial begin
    // Reset with clk1 already high and d1 all ones.
    push("reset", 4'h0, 4'hF, 4'h0, 4'hF);
    #0.5; check();
    tick(1);
    rst = 1'b0;
    push("held_trig_no_capture", 4'h0, 4'hF, 4'h0, 4'hF);
    tick(LAT + 2); check();

    // Fresh rise captures d1.
    clk1 = 1'b0; tick(LAT + 1);
    clk1 = 1'b1;
    push("capture_F", 4'hF, 4'h0, 4'h0, 4'hF);
    tick(LAT); check();

    // Trigger held high: new data is not taken.
    d1 = 4'h5;
    push("single_capture", 4'hF, 4'h0, 4'h0, 4'hF);
    tick(LAT + 2); check();
    clk1 = 1'b0; tick(LAT + 1);
    clk1 = 1'b1;
    push("capture_5", 4'h5, 4'hA, 4'h0, 4'hF);
    tick(LAT); check();

    // Clear is immediate; a rise during clear is consumed.
    clr1_n = 1'b0; d1 = 4'hF;
    push("clr_async", 4'h0, 4'hF, 4'h0, 4'hF);
    #0.3; check();
    tick(1);
    clk1 = 1'b0; tick(LAT + 1);
    clk1 = 1'b1; tick(LAT + 1);
    clr1_n = 1'b1;
    push("clr_release_hold", 4'h0, 4'hF, 4'h0, 4'hF);
    tick(LAT + 2); check();
    clk1 = 1'b0; tick(LAT + 1);
    clk1 = 1'b1;
    push("capture_after_clr", 4'hF, 4'h0, 4'h0, 4'hF);
    tick(LAT); check();

    // Channel 2 capture, then preset.
    d2 = 4'hA; clk2 = 1'b1;
    push("ch2_capture_A", 4'hF, 4'h0, 4'hA, 4'h5);
    tick(LAT); check();
    d2 = 4'h0; pr2_n = 1'b0;
    push("pr2_async", 4'hF, 4'h0, 4'hF, 4'h0);
    #0.3; check();
    tick(4);
    clk2 = 1'b0;
    pr2_n = 1'b1;
    push("pr2_release_hold", 4'hF, 4'h0, 4'hF, 4'h0);
    tick(LAT + 1); check();
    clk2 = 1'b1;
    push("ch2_capture_0", 4'hF, 4'h0, 4'h0, 4'hF);
    tick(LAT); check();

    // Both low on channel 1: both outputs high; release clear only.
    clr1_n = 1'b0; pr1_n = 1'b0;
    push("both_low", 4'hF, 4'hF, 4'h0, 4'hF);
    #0.3; check();
    tick(2);
    clr1_n = 1'b1;
    push("release_clr_only", 4'hF, 4'h0, 4'h0, 4'hF);
    #0.3; check();
    tick(1);
    pr1_n = 1'b1;
    push("release_pr_keeps", 4'hF, 4'h0, 4'h0, 4'hF);
    tick(2); check();

    // Mid-operation reset drops a pending capture.
    clk1 = 1'b0; d1 = 4'h3; tick(LAT + 1);
    clk1 = 1'b1; rst = 1'b1;
    push("rst_midop", 4'h0, 4'hF, 4'h0, 4'hF);
    #0.3; check();
    tick(1);
    pr2_n = 1'b0;
    push("rst_over_pr", 4'h0, 4'hF, 4'h0, 4'hF);
    #0.3; check();
    tick(1);
    pr2_n = 1'b1; rst = 1'b0;
    push("rst_release_no_capture", 4'h0, 4'hF, 4'h0, 4'hF);
    tick(LAT + 2); check();

    // Both channels from periodic triggers; clr1 pulses do not disturb channel 2.
    d1 = 4'h9; d2 = 4'h6; clk1 = 1'b0; clk2 = 1'b0;
    tick(LAT + 1);
    clk1 = 1'b1; clk2 = 1'b1;
    push("dual_capture", 4'h9, 4'h6, 4'h6, 4'h9);
    tick(LAT); check();
    clr1_n = 1'b0;
    push("clr1_ch2_intact", 4'h0, 4'hF, 4'h6, 4'h9);
    tick(1); check();
    clr1_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/sn74ls74_dual.md
SN74LS74_DUAL -- requirements
Module: sn74ls74_dual

Interface
REQ-001 Parameter: WIDTH, default 1, data bits per channel (1..32).
REQ-002 Port: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Ports: clk1 / clk2  input  1  channel trigger inputs, sampled by clk; not clocks.
REQ-005 Ports: d1 / d2  input  WIDTH  channel data.
REQ-006 Ports: clr1_n / clr2_n  input  1  channel clear, asynchronous, active-low.
REQ-007 Ports: pr1_n / pr2_n  input  1  channel preset, asynchronous, active-low.
REQ-008 Ports: q1 / q2  output  WIDTH  channel state.
REQ-009 Ports: q1_n / q2_n  output  WIDTH  complement outputs.

Function
REQ-010 Two channels, identical, fully independent except for shared clk and rst.
REQ-011 Each channel keeps a trigger-history bit prev_N, loaded with the sampled trigger on every clk edge.
REQ-012 Capture: on a clk edge where the sampled trigger is 1 and prev_N is 0, the channel loads qN <= dN (sampled on the same edge); latency 1 clk after trigger rise is seen.
REQ-013 No rising trigger: qN holds; a trigger held high captures exactly once.
REQ-014 Priority per channel, highest first: rst; clrN_n=0 and prN_n=0; clrN_n=0; prN_n=0; capture; hold.
REQ-015 clrN_n=0 alone: qN = all 0, qN_n = all 1, immediately (asynchronous), capture ignored.
REQ-016 prN_n=0 alone: qN = all 1, qN_n = all 0, immediately, capture ignored.
REQ-017 Both low: qN = all 1 and qN_n = all 1 (74LS74 illegal state reproduced).
REQ-018 On release of clr/pr, qN keeps forced value until the next capture; qN_n returns to ~qN on release of the both-low state.
REQ-019 Outside REQ-017, qN_n = ~qN bitwise at all times.
REQ-020 prev_N keeps updating while clr/pr are asserted; a trigger rise during clr/pr is consumed, not deferred.

Reset
REQ-021 rst=1: q1=q2=0, q1_n=q2_n=all 1, prev_1=prev_2=1, synchronizer stages (if present) = 0 for data and 1 for triggers.
REQ-022 prev_N reset to 1 so a trigger already high at rst release does not capture.
REQ-023 rst overrides clr/pr; mid-operation rst discards any pending capture.

Configuration
REQ-024 Macro SN74LS74_SYNC_EN defined: clkN and dN each pass through a 2-stage synchronizer before edge detect; capture latency becomes 3 clk from trigger rise; clr/pr remain asynchronous.
REQ-025 Macro absent: no synchronizer, behaviour per REQ-012 (latency 1 clk).

Structure
REQ-026 Package sn74ls74_pkg: WIDTH default constant, synchronizer depth constant (2), reset values of prev and q.
REQ-027 One sub-module sn74ls74_ff implements one channel (sync, edge detect, forcing logic); top instantiates it twice.

Verification
REQ-028 rst=1 then 0 with clk1=1 held, d1=1 -> q1 stays 0, q1_n=1 until a new trigger rise.
REQ-029 clr1_n=0 for 10 ns while d1=1, clk1 toggling -> q1=0 immediately, q1_n=1; after release q1=1 only following next clk1 rise.
REQ-030 pr2_n=0 for 10 ns, d2=0 -> q2=1, q2_n=0 immediately; after release next clk2 rise -> q2=0.
REQ-031 clr1_n=0 and pr1_n=0 together -> q1=1, q1_n=1; release clr1_n only -> q1=1, q1_n=0.
REQ-032 d1=1, d2=1, clk1/clk2 period 10 ns, clk period 2 ns -> q1=q2=1 one clk after each detected rise (three with SYNC_EN); channel 2 unaffected by clr1_n activity.
